// File: rtl/lcd_sprite_gen_if.sv
// Pixel-path bundle between timing generator, sprite generator, image ROM and pixel FIFO.
// FIFOWe qualifies RGBData for one cycle; there is no ready, the FIFO must accept every strobe.
interface lcd_sprite_gen_if #(
  parameter int DATA_W = 8,
  parameter int ROM_AW = 15
);
  logic              HSYNC;
  logic              VSYNC;
  logic [DATA_W-1:0] RomData;
  logic [ROM_AW-1:0] RomAddr;
  logic              FIFOWe;
  logic [DATA_W-1:0] RGBData;
  // Motion and line-counter state, exposed for observation
  logic [15:0]       dbg_x;
  logic [15:0]       dbg_y;
  logic              dbg_dir_x;
  logic              dbg_dir_y;
  logic [15:0]       dbg_line;

  modport master (
    output HSYNC, VSYNC, RomData,
    input  RomAddr, FIFOWe, RGBData,
    input  dbg_x, dbg_y, dbg_dir_x, dbg_dir_y, dbg_line
  );

  modport slave (
    input  HSYNC, VSYNC, RomData,
    output RomAddr, FIFOWe, RGBData,
    output dbg_x, dbg_y, dbg_dir_x, dbg_dir_y, dbg_line
  );
endinterface

// File: rtl/lcd_sprite_gen.sv
// Line/frame pixel generator overlaying a bouncing ROM sprite on a constant background.
// Define LCD_SPRITE_VMOVE_EN to let the sprite bounce vertically as well as horizontally.
module lcd_sprite_gen #(
  parameter int                LINE_PIX     = 1600,
  parameter int                ACTIVE_LINES = 480,
  parameter int                SPR_W        = 256,
  parameter int                SPR_H        = 128,
  parameter int                STEP_X       = 16,
  parameter int                STEP_Y       = 4,
  parameter int                DATA_W       = 8,
  parameter int                ROM_AW       = 15,
  parameter logic [DATA_W-1:0] BG_COLOR     = '1
) (
  input logic             CLK,
  input logic             nRST,
  lcd_sprite_gen_if.slave bus
);

  localparam logic [15:0] LINE_PIX16 = 16'(LINE_PIX);
  localparam logic [16:0] SPR_W17    = 17'(SPR_W);
  localparam logic [16:0] SPR_H17    = 17'(SPR_H);
  localparam logic [16:0] STEP_X17   = 17'(STEP_X);
  localparam logic [15:0] STEP_X16   = 16'(STEP_X);
  localparam logic [16:0] XMAX       = 17'(LINE_PIX - SPR_W);

  logic [15:0]       pix_q, pix_d, line_q, line_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic              vsync_q, we_q, spr_q;
  logic              active, in_spr, vs_rise;
  logic [16:0]       x_inc;

  always_comb begin
    active  = !bus.HSYNC && !bus.VSYNC && (pix_q < LINE_PIX16);
    in_spr  = active
              && ({1'b0, pix_q} >= {1'b0, x_q}) && ({1'b0, pix_q} < ({1'b0, x_q} + SPR_W17))
              && ({1'b0, line_q} >= {1'b0, y_q}) && ({1'b0, line_q} < ({1'b0, y_q} + SPR_H17));
    vs_rise = bus.VSYNC && !vsync_q;

    pix_d = pix_q;
    if (bus.HSYNC || bus.VSYNC)   pix_d = '0;
    else if (pix_q < LINE_PIX16)  pix_d = pix_q + 16'd1;

    line_d = line_q;
    if (bus.VSYNC) line_d = '0;
    else if (active && (pix_q == LINE_PIX16 - 16'd1) && (line_q != 16'hFFFF))
      line_d = line_q + 16'd1;

    addr_d = addr_q;
    if (bus.VSYNC)   addr_d = '0;
    else if (in_spr) addr_d = addr_q + 1'b1;
  end

  // Horizontal bounce: clamp to the wall and reverse when the next step would reach it
  always_comb begin
    x_inc   = {1'b0, x_q} + STEP_X17;
    x_d     = x_q;
    dir_x_d = dir_x_q;
    if (vs_rise) begin
      if (!dir_x_q) begin
        if (x_inc >= XMAX) begin
          x_d     = XMAX[15:0];
          dir_x_d = 1'b1;
        end else begin
          x_d = x_inc[15:0];
        end
      end else if ({1'b0, x_q} <= STEP_X17) begin
        x_d     = '0;
        dir_x_d = 1'b0;
      end else begin
        x_d = x_q - STEP_X16;
      end
    end
  end

`ifdef LCD_SPRITE_VMOVE_EN
  localparam logic [16:0] STEP_Y17 = 17'(STEP_Y);
  localparam logic [15:0] STEP_Y16 = 16'(STEP_Y);
  localparam logic [16:0] YMAX     = 17'(ACTIVE_LINES - SPR_H);
  logic [16:0] y_inc;

  always_comb begin
    y_inc   = {1'b0, y_q} + STEP_Y17;
    y_d     = y_q;
    dir_y_d = dir_y_q;
    if (vs_rise) begin
      if (!dir_y_q) begin
        if (y_inc >= YMAX) begin
          y_d     = YMAX[15:0];
          dir_y_d = 1'b1;
        end else begin
          y_d = y_inc[15:0];
        end
      end else if ({1'b0, y_q} <= STEP_Y17) begin
        y_d     = '0;
        dir_y_d = 1'b0;
      end else begin
        y_d = y_q - STEP_Y16;
      end
    end
  end
`else
  always_comb begin
    y_d     = '0;
    dir_y_d = 1'b0;
  end
`endif

  // vsync_q resets high so a VSYNC already asserted when reset releases is not taken as a new frame
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pix_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      vsync_q <= 1'b1;
      we_q    <= 1'b0;
      spr_q   <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      vsync_q <= bus.VSYNC;
      we_q    <= active;
      spr_q   <= in_spr;
    end
  end

  assign bus.RomAddr   = addr_q;
  assign bus.FIFOWe    = we_q;
  assign bus.RGBData   = spr_q ? bus.RomData : BG_COLOR;
  assign bus.dbg_x     = x_q;
  assign bus.dbg_y     = y_q;
  assign bus.dbg_dir_x = dir_x_q;
  assign bus.dbg_dir_y = dir_y_q;
  assign bus.dbg_line  = line_q;

endmodule
